tile_map_server: RTL and testbench

Owns the 20×15 battlefield tile map that tank movement logic reads, and serves tile lookups to both tanks over a valid/ready handshake. Applies wall-destruction writes from bullet impacts and provides a registered read port for the renderer. On reset it rebuilds the default map, then arbitrates the two tank query ports round-robin. It sits between the tank/bullet logic and the VGA color mapper.

---
 rtl/tile_pkg.sv | 40 ++++
 rtl/tile_rr_arbiter.sv | 39 +++
 rtl/tile_map_server.sv | 169 ++++++++++++++++
 tb/tb_tile_map_server.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared tile-map types and helpers: tile codes, controller states, map geometry,
// linear tile indexing and the default battlefield layout.
package tile_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BRICK = 2'd1,
        STEEL = 2'd2,
        WATER = 2'd3
    } tile_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAP_W    = 20;
    localparam int MAP_H    = 15;
    localparam int MAP_SIZE = 300;

    localparam logic [8:0] LAST_IDX = 9'(MAP_SIZE - 1);

    // row*20 built from shifts so no multiplier is needed.
    function automatic logic [8:0] tile_index(input logic [4:0] col, input logic [4:0] row);
        logic [8:0] row9;
        row9 = {4'b0000, row};
        return (row9 << 4) + (row9 << 2) + {4'b0000, col};
    endfunction

    function automatic tile_t default_tile(input logic [4:0] col, input logic [4:0] row);
        if (row == 5'd0 || row == 5'(MAP_H - 1) || col == 5'd0 || col == 5'(MAP_W - 1)) begin
            return STEEL;
        end
        if (col[1:0] == 2'd2 && row[1:0] == 2'd2) begin
            return BRICK;
        end
        return EMPTY;
    endfunction

endpackage

// File: rtl/tile_rr_arbiter.sv
// Two-port round-robin arbiter; on a tie the port not granted last wins.
module tile_rr_arbiter
    import tile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       last_q
);

    logic last_d;

    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (grant[0]) begin
            last_d = 1'b0;
        end else if (grant[1]) begin
            last_d = 1'b1;
        end
    end

    // Pointer starts on port 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/tile_map_server.sv
// Battlefield tile map: rebuilds the default layout after reset, then serves
// round-robin tank lookups, bullet brick destruction and a registered render port.
module tile_map_server #(
    parameter int MAP_W = 20,
    parameter int MAP_H = 15
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [1:0]       q_valid,
    input  logic [1:0][9:0]  q_x,
    input  logic [1:0][9:0]  q_y,
    output logic [1:0]       q_ready,
    output logic [1:0]       rsp_valid,
    output logic [1:0][1:0]  rsp_tile,
    input  logic             hit_valid,
    input  logic [4:0]       hit_x,
    input  logic [3:0]       hit_y,
    input  logic [4:0]       rd_x,
    input  logic [3:0]       rd_y,
    output logic [1:0]       rd_tile,
    output logic             init_busy,
    output logic [7:0]       bricks_left
);

    import tile_pkg::*;

    localparam logic [4:0] COL_LIM = 5'(MAP_W);
    localparam logic [4:0] ROW_LIM = 5'(MAP_H);

    function automatic logic in_map(input logic [4:0] col, input logic [4:0] row);
        return (col < COL_LIM) && (row < ROW_LIM);
    endfunction

    state_t          state_q, state_d;
    logic [8:0]      idx_q, idx_d;
    logic [4:0]      col_q, col_d;
    logic [4:0]      row_q, row_d;
    logic [7:0]      bricks_q, bricks_d;
    tile_t           map_q [MAP_SIZE];
    tile_t           map_d [MAP_SIZE];
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [1:0][1:0] rsp_tile_q, rsp_tile_d;
    logic [1:0]      rd_tile_q, rd_tile_d;

    logic [1:0]      arb_req;
    logic [1:0]      grant;
    logic [1:0][1:0] q_tile;
    logic [4:0]      hit_row;
    logic [4:0]      rd_row;
    logic [8:0]      hit_idx;
    logic            hit_brick;
    logic            rr_last_unused;
    logic            pixel_offset_unused;

    // Pixel offsets inside a tile never affect which tile is looked up.
    assign pixel_offset_unused = ^{q_x[0][4:0], q_x[1][4:0], q_y[0][4:0], q_y[1][4:0]};

    assign arb_req = (state_q == RUN) ? q_valid : 2'b00;

    tile_rr_arbiter u_arbiter (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .req    (arb_req),
        .grant  (grant),
        .last_q (rr_last_unused)
    );

    assign hit_row   = {1'b0, hit_y};
    assign rd_row    = {1'b0, rd_y};
    assign hit_idx   = tile_index(hit_x, hit_row);
    assign hit_brick = hit_valid && in_map(hit_x, hit_row) && (map_q[hit_idx] == BRICK);

    always_comb begin
        q_tile = '0;
        for (int i = 0; i < 2; i++) begin
            if (in_map(q_x[i][9:5], q_y[i][9:5])) begin
                q_tile[i] = map_q[tile_index(q_x[i][9:5], q_y[i][9:5])];
            end else begin
                q_tile[i] = STEEL;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        col_d    = col_q;
        row_d    = row_q;
        bricks_d = bricks_q;
        map_d    = map_q;
        case (state_q)
            INIT: begin
                map_d[idx_q] = default_tile(col_q, row_q);
                if (default_tile(col_q, row_q) == BRICK) begin
                    bricks_d = bricks_q + 8'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    idx_d = idx_q + 9'd1;
                    if (col_q == COL_LIM - 5'd1) begin
                        col_d = 5'd0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            RUN: begin
                if (hit_brick) begin
                    map_d[hit_idx] = EMPTY;
                    bricks_d       = bricks_q - 8'd1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Responses read map_q before this edge's hit write, giving read-before-write.
    always_comb begin
        rsp_valid_d = grant;
        rsp_tile_d  = rsp_tile_q;
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
                rsp_tile_d[i] = q_tile[i];
            end
        end
        if (in_map(rd_x, rd_row)) begin
            rd_tile_d = map_q[tile_index(rd_x, rd_row)];
        end else begin
            rd_tile_d = STEEL;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= INIT;
            idx_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            bricks_q    <= '0;
            rsp_valid_q <= '0;
            rsp_tile_q  <= '0;
            rd_tile_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bricks_q    <= bricks_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tile_q  <= rsp_tile_d;
            rd_tile_q   <= rd_tile_d;
        end
    end

    // The map itself needs no reset: INIT rewrites every entry.
    always_ff @(posedge Clk) begin
        map_q <= map_d;
    end

    assign q_ready     = grant;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_tile    = rsp_tile_q;
    assign rd_tile     = rd_tile_q;
    assign init_busy   = (state_q == INIT);
    assign bricks_left = bricks_q;

endmodule

// File: tb/tb_tile_map_server.sv
// Self-checking bench for tile_map_server: directed steps plus a randomized phase
// scored against a tile-array reference model of the battlefield.
module tb_tile_map_server;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic [1:0]      q_valid;
    logic [1:0][9:0] q_x;
    logic [1:0][9:0] q_y;
    logic [1:0]      q_ready;
    logic [1:0]      rsp_valid;
    logic [1:0][1:0] rsp_tile;
    logic            hit_valid;
    logic [4:0]      hit_x;
    logic [3:0]      hit_y;
    logic [4:0]      rd_x;
    logic [3:0]      rd_y;
    logic [1:0]      rd_tile;
    logic            init_busy;
    logic [7:0]      bricks_left;

    int errors = 0;
    int checks = 0;
    int model_map [20][15];
    int model_bricks;
    int model_last;

    tile_map_server #(.MAP_W(20), .MAP_H(15)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .q_valid     (q_valid),
        .q_x         (q_x),
        .q_y         (q_y),
        .q_ready     (q_ready),
        .rsp_valid   (rsp_valid),
        .rsp_tile    (rsp_tile),
        .hit_valid   (hit_valid),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_tile     (rd_tile),
        .init_busy   (init_busy),
        .bricks_left (bricks_left)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int defaultTile(input int c, input int r);
        if (r == 0 || r == 14 || c == 0 || c == 19) return 2;
        if (c % 4 == 2 && r % 4 == 2) return 1;
        return 0;
    endfunction

    task automatic modelReset();
        model_bricks = 0;
        for (int c = 0; c < 20; c++) begin
            for (int r = 0; r < 15; r++) begin
                model_map[c][r] = defaultTile(c, r);
                if (model_map[c][r] == 1) model_bricks++;
            end
        end
        model_last = 1;
    endtask

    function automatic int modelLookup(input int c, input int r);
        if (c >= 20 || r >= 15) return 2;
        return model_map[c][r];
    endfunction

    task automatic modelHit(input int c, input int r);
        if (c < 20 && r < 15 && model_map[c][r] == 1) begin
            model_map[c][r] = 0;
            model_bricks--;
        end
    endtask

    function automatic int predictGrant(input logic [1:0] pend);
        if (pend == 2'b01) return 0;
        if (pend == 2'b10) return 1;
        if (pend == 2'b11) return (model_last == 1) ? 0 : 1;
        return -1;
    endfunction

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic applyStimulus(input logic [1:0] v, input int x0, input int y0, input int x1, input int y1,
                                 input logic hv, input int hx, input int hy, input int rx, input int ry);
        q_valid   = v;
        q_x[0]    = 10'(x0);
        q_y[0]    = 10'(y0);
        q_x[1]    = 10'(x1);
        q_y[1]    = 10'(y1);
        hit_valid = hv;
        hit_x     = 5'(hx);
        hit_y     = 4'(hy);
        rd_x      = 5'(rx);
        rd_y      = 4'(ry);
    endtask

    task automatic queryOne(input int port, input int x, input int y, input string tag);
        int expTile;
        if (port == 0) applyStimulus(2'b01, x, y, 0, 0, 1'b0, 0, 0, 0, 0);
        else           applyStimulus(2'b10, 0, 0, x, y, 1'b0, 0, 0, 0, 0);
        #1;
        checkOutput({tag, "_ready"}, 32'(q_ready), 32'(1 << port));
        expTile    = modelLookup(x >> 5, y >> 5);
        model_last = port;
        tick();
        q_valid = 2'b00;
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << port));
        checkOutput({tag, "_rsp_tile"}, 32'(rsp_tile[port]), 32'(expTile));
    endtask

    task automatic hitOne(input int hx, input int hy, input string tag);
        applyStimulus(2'b00, 0, 0, 0, 0, 1'b1, hx, hy, 0, 0);
        modelHit(hx, hy);
        tick();
        hit_valid = 1'b0;
        checkOutput({tag, "_bricks"}, 32'(bricks_left), 32'(model_bricks));
    endtask

    task automatic renderOne(input int rx, input int ry, input string tag);
        applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, rx, ry);
        tick();
        checkOutput({tag, "_rd_tile"}, 32'(rd_tile), 32'(modelLookup(rx, ry)));
    endtask

    task automatic waitInitDone(input int startCount, output int cycles);
        cycles = startCount;
        while (init_busy === 1'b1 && cycles < 400) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cycles;
        int g;
        int expRdy;
        int expTile;
        int expRd;
        int partial;
        int hx, hy, rx, ry;
        logic hv;
        logic [1:0] pend;
        int px [2];
        int py [2];

        // Reset and default-map build.
        Reset_n = 1'b0;
        applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
        modelReset();
        tick();
        tick();
        checkOutput("reset_q_ready", 32'(q_ready), 0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset_rsp_tile", 32'(rsp_tile), 0);
        checkOutput("reset_rd_tile", 32'(rd_tile), 0);
        checkOutput("reset_init_busy", 32'(init_busy), 1);
        checkOutput("reset_bricks", 32'(bricks_left), 0);

        Reset_n = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        q_valid = 2'b11;
        #1;
        checkOutput("init_q_ready", 32'(q_ready), 0);
        q_valid = 2'b00;
        waitInitDone(100, cycles);
        checkOutput("init_cycles", 32'(cycles), 300);
        checkOutput("init_bricks", 32'(bricks_left), 32'(model_bricks));

        // Render port on defaults and out-of-range coordinates.
        renderOne(0, 0, "rd_0_0");
        renderOne(2, 2, "rd_2_2");
        renderOne(3, 3, "rd_3_3");
        renderOne(20, 3, "rd_col20");
        renderOne(4, 15, "rd_row15");

        // First tie after reset goes to port 0, then alternates.
        checkOutput("tie_first_pred", 32'(predictGrant(2'b11)), 0);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(2'b11, 64, 64, 640, 64, 1'b0, 0, 0, 0, 0);
            #1;
            g = predictGrant(2'b11);
            checkOutput("tie_ready", 32'(q_ready), 32'(1 << g));
            expTile    = (g == 0) ? modelLookup(2, 2) : modelLookup(20, 2);
            model_last = g;
            tick();
            checkOutput("tie_rsp_valid", 32'(rsp_valid), 32'(1 << g));
            checkOutput("tie_rsp_tile", 32'(rsp_tile[g]), 32'(expTile));
        end
        q_valid = 2'b00;
        tick();
        checkOutput("rsp_pulse_end", 32'(rsp_valid), 0);

        // Single queries and wall destruction.
        queryOne(0, 64, 64, "q_brick");
        hitOne(2, 2, "hit_brick");
        queryOne(1, 64, 64, "q_cleared");
        hitOne(0, 0, "hit_steel");
        renderOne(0, 0, "rd_steel_kept");
        hitOne(22, 5, "hit_col22");
        renderOne(2, 6, "rd_alias_kept");
        queryOne(0, 640, 64, "q_col20");

        // Hit and query on the same tile in one cycle: old value returned.
        applyStimulus(2'b01, 192, 64, 0, 0, 1'b1, 6, 2, 0, 0);
        #1;
        checkOutput("rbw_ready", 32'(q_ready), 1);
        expTile    = modelLookup(6, 2);
        model_last = 0;
        modelHit(6, 2);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
        checkOutput("rbw_rsp_tile", 32'(rsp_tile[0]), 32'(expTile));
        checkOutput("rbw_bricks", 32'(bricks_left), 32'(model_bricks));
        queryOne(1, 192, 64, "rbw_after");

        // Randomized traffic on all three access paths.
        pend = 2'b00;
        px[0] = 0; py[0] = 0; px[1] = 0; py[1] = 0;
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p] = 1'b1;
                    px[p]   = int'($urandom_range(0, 700));
                    py[p]   = int'($urandom_range(0, 520));
                end
            end
            hv = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                hx = 2 + 4 * int'($urandom_range(0, 4));
                hy = 2 + 4 * int'($urandom_range(0, 2));
            end else begin
                hx = int'($urandom_range(0, 23));
                hy = int'($urandom_range(0, 15));
            end
            rx = int'($urandom_range(0, 23));
            ry = int'($urandom_range(0, 15));
            applyStimulus(pend, px[0], py[0], px[1], py[1], hv, hx, hy, rx, ry);
            #1;
            g      = predictGrant(pend);
            expRdy = (g < 0) ? 0 : (1 << g);
            checkOutput("rnd_ready", 32'(q_ready), 32'(expRdy));
            expTile = (g < 0) ? 0 : modelLookup(px[g] >> 5, py[g] >> 5);
            expRd   = modelLookup(rx, ry);
            if (hv) modelHit(hx, hy);
            tick();
            checkOutput("rnd_rsp_valid", 32'(rsp_valid), 32'(expRdy));
            if (g >= 0) begin
                checkOutput("rnd_rsp_tile", 32'(rsp_tile[g]), 32'(expTile));
                pend[g]    = 1'b0;
                model_last = g;
            end
            checkOutput("rnd_rd_tile", 32'(rd_tile), 32'(expRd));
            checkOutput("rnd_bricks", 32'(bricks_left), 32'(model_bricks));
        end
        applyStimulus(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 2, 2);

        // Reset in the middle of INIT restarts the sweep from scratch.
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        modelReset();
        partial = 0;
        for (int i = 0; i < 150; i++) begin
            if (defaultTile(i % 20, i / 20) == 1) partial++;
            tick();
        end
        checkOutput("mid_init_bricks", 32'(bricks_left), 32'(partial));
        checkOutput("mid_init_rd", 32'(rd_tile), 32'(modelLookup(2, 2)));
        Reset_n = 1'b0;
        tick();
        checkOutput("mid_reset_busy", 32'(init_busy), 1);
        checkOutput("mid_reset_bricks", 32'(bricks_left), 0);
        checkOutput("mid_reset_rd", 32'(rd_tile), 0);
        Reset_n = 1'b1;
        waitInitDone(0, cycles);
        checkOutput("reinit_cycles", 32'(cycles), 300);
        checkOutput("reinit_bricks", 32'(bricks_left), 32'(model_bricks));

        applyStimulus(2'b11, 200, 100, 64, 64, 1'b0, 0, 0, 0, 0);
        #1;
        checkOutput("reinit_tie_ready", 32'(q_ready), 1);
        tick();
        q_valid = 2'b00;
        checkOutput("reinit_tie_rsp", 32'(rsp_valid), 1);
        checkOutput("reinit_tie_tile", 32'(rsp_tile[0]), 32'(modelLookup(6, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
